multi_player_turn_controller: RTL

Parametrised N-player successor of the two-player dice-race turn FSM. It accepts colour-dice results from the camera colour detector and moves the current player along a board of configurable length. It resolves back-to-start and bonus tiles, enforces a per-turn timeout with a countdown, and handshakes every move with the UI animation engine via turn_done. It sits between Color_Result_Manager and the VGA board renderer/FND/LED drivers.

---
 rtl/multi_player_turn_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/multi_player_turn_controller.sv
// N-player dice-race turn controller: moves the current player, resolves board events and paces turns.
// Optional build macro TURN_SEPARATION_EN: dice are accepted only after a white face has been seen this turn.
module multi_player_turn_controller #(
    parameter int NUM_PLAYERS   = 4,
    parameter int BOARD_LEN     = 10,
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int TIMEOUT_TICKS = 8,
    parameter int BACK_TILE     = 3,
    parameter int BONUS_TILE    = 6,
    parameter int EXACT_FINISH  = 0,
    localparam int PW = $clog2(BOARD_LEN + 1),
    localparam int TW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_btn,
    input  logic                      dice_valid,
    input  logic [1:0]                dice_value,
    input  logic                      white_stable,
    input  logic                      turn_done,
    output logic [NUM_PLAYERS*PW-1:0] pos_flat,
    output logic [TW-1:0]             turn_id,
    output logic                      pos_valid,
    output logic [3:0]                event_flag,
    output logic [3:0]                time_left,
    output logic                      winner_valid,
    output logic [TW-1:0]             winner_id,
    output logic [2:0]                dbg_state
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_DICE, MOVE, WAIT_ANIM, CHECK, EVENT_ANIM, NEXT, WIN
    } state_t;

    state_t state, state_nx;

    logic [NUM_PLAYERS-1:0][PW-1:0] pos;
    logic [1:0]    steps;
    logic [CW-1:0] tick_cnt;
    logic          advance;
    logic          tick, dice_ok, timeout;
    logic [PW-1:0] cur_pos, new_pos;
    logic [PW:0]   sum, bounce;

    assign pos_flat  = pos;
    assign dbg_state = state;
    assign cur_pos   = pos[turn_id];
    assign tick      = (state == WAIT_DICE) && (tick_cnt == CW'(TICK_CYCLES - 1));
    assign timeout   = tick && (time_left == 4'd1);

`ifdef TURN_SEPARATION_EN
    logic sep_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sep_flag <= 1'b0;
        else if (state == NEXT || ((state == IDLE || state == WIN) && start_btn))
            sep_flag <= 1'b0;
        else if (state == WAIT_DICE && white_stable)
            sep_flag <= 1'b1;
    end

    assign dice_ok = dice_valid && (dice_value != 2'b00) && sep_flag;
`else
    logic unused_white;
    assign unused_white = white_stable;
    assign dice_ok      = dice_valid && (dice_value != 2'b00);
`endif

    // Sum is one bit wider than a position so overshoot is visible before clamping.
    always_comb begin
        sum    = {1'b0, cur_pos} + {{(PW - 1){1'b0}}, steps};
        bounce = (PW + 1)'(2 * BOARD_LEN) - sum;
        if (sum <= (PW + 1)'(BOARD_LEN))
            new_pos = sum[PW-1:0];
        else if (EXACT_FINISH != 0)
            new_pos = bounce[PW-1:0];
        else
            new_pos = PW'(BOARD_LEN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start_btn) state_nx = WAIT_DICE;
            WAIT_DICE:  if (dice_ok) state_nx = MOVE;
                        else if (timeout) state_nx = NEXT;
            MOVE:       state_nx = WAIT_ANIM;
            WAIT_ANIM:  if (turn_done) state_nx = CHECK;
            CHECK:      if (cur_pos == PW'(BOARD_LEN)) state_nx = WIN;
                        else if (cur_pos == PW'(BACK_TILE)) state_nx = EVENT_ANIM;
                        else state_nx = NEXT;
            EVENT_ANIM: if (turn_done) state_nx = NEXT;
            NEXT:       state_nx = WAIT_DICE;
            WIN:        if (start_btn) state_nx = WAIT_DICE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos          <= '0;
            turn_id      <= '0;
            pos_valid    <= 1'b0;
            event_flag   <= 4'h0;
            time_left    <= 4'(TIMEOUT_TICKS);
            winner_valid <= 1'b0;
            winner_id    <= '0;
            tick_cnt     <= '0;
            steps        <= 2'd0;
            advance      <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN: if (start_btn) begin
                    pos          <= '0;
                    turn_id      <= '0;
                    event_flag   <= 4'h0;
                    winner_valid <= 1'b0;
                    winner_id    <= '0;
                    time_left    <= 4'(TIMEOUT_TICKS);
                    tick_cnt     <= '0;
                    advance      <= 1'b0;
                end
                WAIT_DICE: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    if (tick && time_left != 4'd0) time_left <= time_left - 4'd1;
                    // A dice pulse on the final tick beats the timeout.
                    if (dice_ok) begin
                        steps <= dice_value;
                    end else if (timeout) begin
                        event_flag <= 4'hF;
                        advance    <= 1'b1;
                    end
                end
                MOVE: begin
                    pos[turn_id] <= new_pos;
                    pos_valid    <= 1'b1;
                end
                WAIT_ANIM: if (turn_done) pos_valid <= 1'b0;
                CHECK: begin
                    if (cur_pos == PW'(BOARD_LEN)) begin
                        winner_valid <= 1'b1;
                        winner_id    <= turn_id;
                        event_flag   <= 4'hA;
                    end else if (cur_pos == PW'(BACK_TILE)) begin
                        pos[turn_id] <= '0;
                        event_flag   <= 4'h3;
                        advance      <= 1'b1;
                    end else if (cur_pos == PW'(BONUS_TILE)) begin
                        event_flag   <= 4'h5;
                        advance      <= 1'b0;
                    end else begin
                        event_flag   <= 4'h1;
                        advance      <= 1'b1;
                    end
                end
                NEXT: begin
                    time_left <= 4'(TIMEOUT_TICKS);
                    tick_cnt  <= '0;
                    advance   <= 1'b0;
                    if (advance)
                        turn_id <= (turn_id == TW'(NUM_PLAYERS - 1)) ? '0 : turn_id + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
